// File: rtl/msgpass_rd_addr_gen.sv
// Read-address sequencer for the message-pass buffer: walks port-A over a programmed window, stalls on conflicts.
// Optional stall counter output enabled by defining MSGPASS_ADDRGEN_STALL_CNT_EN.
module msgpass_rd_addr_gen #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DRC_NUM    = 1
) (
   input  logic                  sys_clk,
   input  logic                  rstn,
   input  logic                  buffer_read_begin_i,
   input  logic                  buffer_read_end_i,
   input  logic [ADDR_WIDTH-1:0] start_addr_i,
   input  logic [ADDR_WIDTH-1:0] last_addr_i,
   input  logic [DRC_NUM-1:0]    is_drc_i,
   output logic [ADDR_WIDTH-1:0] raddr_o,
   output logic                  cen_o,
   output logic                  rdata_valid_o,
   output logic                  wrap_o,
   output logic                  busy_o
`ifdef MSGPASS_ADDRGEN_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt_o
`endif
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [ADDR_WIDTH-1:0] start_q, start_d;
   logic [ADDR_WIDTH-1:0] last_q, last_d;
   logic                  cen_q, cen_d;
   logic                  rvalid_q, rvalid_d;
   logic                  wrap_q, wrap_d;
   logic                  busy_q, busy_d;
   logic                  accept_begin;
   logic                  advance;

   assign accept_begin = buffer_read_begin_i & ~buffer_read_end_i;
   assign advance      = ~|is_drc_i;

   // Next-state and registered-output logic; end beats begin in IDLE and beats advance in RUN
   always_comb begin
      state_d  = state_q;
      raddr_d  = raddr_q;
      start_d  = start_q;
      last_d   = last_q;
      cen_d    = cen_q;
      rvalid_d = cen_q;
      wrap_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cen_d = 1'b0;
            if (accept_begin) begin
               start_d = start_addr_i;
               last_d  = last_addr_i;
               raddr_d = start_addr_i;
               cen_d   = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (buffer_read_end_i) begin
               cen_d   = 1'b0;
               state_d = ST_DRAIN;
            end else if (advance) begin
               if (raddr_q == last_q) begin
                  raddr_d = start_q;
                  wrap_d  = 1'b1;
               end else begin
                  raddr_d = raddr_q + ADDR_WIDTH'(1);
               end
            end
         end
         ST_DRAIN: begin
            cen_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            cen_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         raddr_q  <= '0;
         start_q  <= '0;
         last_q   <= '0;
         cen_q    <= 1'b0;
         rvalid_q <= 1'b0;
         wrap_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         raddr_q  <= raddr_d;
         start_q  <= start_d;
         last_q   <= last_d;
         cen_q    <= cen_d;
         rvalid_q <= rvalid_d;
         wrap_q   <= wrap_d;
         busy_q   <= busy_d;
      end
   end

   assign raddr_o       = raddr_q;
   assign cen_o         = cen_q;
   assign rdata_valid_o = rvalid_q;
   assign wrap_o        = wrap_q;
   assign busy_o        = busy_q;

`ifdef MSGPASS_ADDRGEN_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of stalled RUN cycles, cleared by an accepted begin
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == ST_IDLE && accept_begin) begin
         stall_cnt_d = '0;
      end else if (state_q == ST_RUN && !advance && stall_cnt_q != {CNT_W{1'b1}}) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_msgpass_rd_addr_gen.sv
// Bench for msgpass_rd_addr_gen: directed test-plan scenarios plus random traffic against a window-offset model.
module tb_msgpass_rd_addr_gen;

   localparam int unsigned AW  = 4;
   localparam int          MOD = 1 << AW;

   logic          sys_clk = 1'b0;
   logic          rstn;
   logic          b_i, e_i;
   logic [AW-1:0] sa_i, la_i;
   logic [0:0]    drc_i;
   logic [AW-1:0] raddr_o;
   logic          cen_o, rdata_valid_o, wrap_o, busy_o;
`ifdef MSGPASS_ADDRGEN_STALL_CNT_EN
   logic [15:0]   stall_cnt_o;
`endif

   int errors = 0;
   int checks = 0;

   always #5 sys_clk = ~sys_clk;

   msgpass_rd_addr_gen #(.ADDR_WIDTH(AW), .DRC_NUM(1)) dut (
      .sys_clk             (sys_clk),
      .rstn                (rstn),
      .buffer_read_begin_i (b_i),
      .buffer_read_end_i   (e_i),
      .start_addr_i        (sa_i),
      .last_addr_i         (la_i),
      .is_drc_i            (drc_i),
      .raddr_o             (raddr_o),
      .cen_o               (cen_o),
      .rdata_valid_o       (rdata_valid_o),
      .wrap_o              (wrap_o),
      .busy_o              (busy_o)
`ifdef MSGPASS_ADDRGEN_STALL_CNT_EN
      ,
      .stall_cnt_o         (stall_cnt_o)
`endif
   );

   logic [AW+3:0] dvec;
   assign dvec = {raddr_o, cen_o, rdata_valid_o, wrap_o, busy_o};

   // Reference: address = start + (advances mod window length), modulo 2^AW
   typedef enum {M_IDLE, M_RUN, M_DRAIN} mst_e;
   mst_e    m_st;
   int      m_start, m_last, m_n, m_stall;
   logic [AW-1:0] m_raddr;
   logic    m_cen, m_rv, m_wrap, m_busy;

   function automatic logic [AW+3:0] mvec();
      return {m_raddr, m_cen, m_rv, m_wrap, m_busy};
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_start = 0; m_last = 0; m_n = 0; m_stall = 0;
      m_raddr = '0; m_cen = 0; m_rv = 0; m_wrap = 0; m_busy = 0;
   endtask

   task automatic model_step();
      logic nrv;
      int   len, k;
      if (!rstn) begin
         model_reset();
         return;
      end
      nrv    = m_cen;
      m_wrap = 0;
      case (m_st)
         M_IDLE: begin
            m_cen = 0;
            if (b_i && !e_i) begin
               m_start = int'(sa_i); m_last = int'(la_i); m_n = 0;
               m_raddr = sa_i; m_cen = 1; m_st = M_RUN; m_stall = 0;
            end
         end
         M_RUN: begin
            if (drc_i != 0 && m_stall < 65535) m_stall++;
            if (e_i) begin
               m_cen = 0; m_st = M_DRAIN;
            end else if (drc_i == 0) begin
               m_n++;
               len = ((m_last - m_start + MOD) % MOD) + 1;
               k = m_n % len;
               m_raddr = AW'((m_start + k) % MOD);
               m_wrap = (k == 0);
            end
         end
         default: begin
            m_cen = 0; m_st = M_IDLE;
         end
      endcase
      m_rv   = nrv;
      m_busy = (m_st != M_IDLE);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      model_step();
      #1;
   endtask

   task automatic stop_run();
      e_i = 1; tick(); e_i = 0; tick();
   endtask

   task automatic test_reset();
      rstn = 0; b_i = 0; e_i = 0; sa_i = '0; la_i = '0; drc_i = '0;
      model_reset();
      #12;
      checks++;
      if (dvec !== '0) begin errors++; $display("FAIL reset_vec got=%h exp=0", dvec); end
      rstn = 1;
      tick();
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL reset_idle got=%h exp=%h", dvec, mvec()); end
   endtask

   task automatic test_basic_walk();
      int exp_a [6] = '{0, 1, 2, 3, 4, 0};
      sa_i = 4'd0; la_i = 4'd4; b_i = 1;
      for (int i = 0; i < 6; i++) begin
         tick(); b_i = 0;
         checks++;
         if (dvec !== mvec()) begin errors++; $display("FAIL walk_model[%0d] got=%h exp=%h", i, dvec, mvec()); end
         checks++;
         if (raddr_o !== AW'(exp_a[i]) || wrap_o !== (i == 5) || rdata_valid_o !== (i != 0) || cen_o !== 1'b1) begin
            errors++;
            $display("FAIL walk_seq[%0d] got a=%0d w=%b v=%b c=%b exp a=%0d w=%b", i, raddr_o, wrap_o, rdata_valid_o, cen_o, exp_a[i], i == 5);
         end
      end
      stop_run();
   endtask

   task automatic test_conflict_stall();
      int exp_a [9] = '{0, 1, 2, 2, 3, 4, 5, 5, 6};
      sa_i = 4'd0; la_i = 4'd7; b_i = 1;
      tick(); b_i = 0;
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (raddr_o !== AW'(exp_a[i]) || dvec !== mvec()) begin
            errors++; $display("FAIL stall_seq[%0d] got a=%0d vec=%h exp a=%0d vec=%h", i, raddr_o, dvec, exp_a[i], mvec());
         end
         drc_i = (i == 2 || i == 6) ? 1'b1 : 1'b0;
         if (i < 8) tick();
      end
      drc_i = 0;
`ifdef MSGPASS_ADDRGEN_STALL_CNT_EN
      checks++;
      if (stall_cnt_o !== 16'd2) begin errors++; $display("FAIL stall_cnt got=%0d exp=2", stall_cnt_o); end
`endif
      stop_run();
   endtask

   task automatic test_rollover();
      int exp_a [5] = '{14, 15, 0, 1, 14};
      sa_i = 4'd14; la_i = 4'd1; b_i = 1;
      for (int i = 0; i < 5; i++) begin
         tick(); b_i = 0;
         checks++;
         if (raddr_o !== AW'(exp_a[i]) || wrap_o !== (i == 4) || dvec !== mvec()) begin
            errors++; $display("FAIL roll_seq[%0d] got a=%0d w=%b exp a=%0d w=%b", i, raddr_o, wrap_o, exp_a[i], i == 4);
         end
      end
      stop_run();
   endtask

   task automatic test_stop_drain();
      sa_i = 4'd0; la_i = 4'd9; b_i = 1;
      tick(); b_i = 0;
      tick(); tick(); tick();
      checks++;
      if (raddr_o !== 4'd3) begin errors++; $display("FAIL drain_pre got=%0d exp=3", raddr_o); end
      e_i = 1; tick(); e_i = 0;
      checks++;
      if ({raddr_o, cen_o, rdata_valid_o, busy_o} !== {4'd3, 3'b011} || dvec !== mvec()) begin
         errors++; $display("FAIL drain_k got=%h exp=%h", dvec, mvec());
      end
      tick();
      checks++;
      if ({raddr_o, cen_o, rdata_valid_o, busy_o} !== {4'd3, 3'b000} || dvec !== mvec()) begin
         errors++; $display("FAIL drain_k1 got=%h exp=%h", dvec, mvec());
      end
      e_i = 1; tick(); e_i = 0; tick();
      checks++;
      if ({raddr_o, cen_o, rdata_valid_o, busy_o} !== {4'd3, 3'b000} || dvec !== mvec()) begin
         errors++; $display("FAIL idle_end got=%h exp=%h", dvec, mvec());
      end
   endtask

   task automatic test_pulses();
      sa_i = 4'd5; la_i = 4'd6; b_i = 1; e_i = 1;
      tick(); b_i = 0; e_i = 0;
      checks++;
      if (cen_o !== 1'b0 || busy_o !== 1'b0 || dvec !== mvec()) begin
         errors++; $display("FAIL begin_end got=%h exp=%h", dvec, mvec());
      end
      sa_i = 4'd2; la_i = 4'd8; b_i = 1;
      tick(); b_i = 0;
      tick();
      sa_i = 4'd11; la_i = 4'd12; b_i = 1;
      tick(); b_i = 0;
      checks++;
      if (raddr_o !== 4'd4 || dvec !== mvec()) begin
         errors++; $display("FAIL run_begin got a=%0d vec=%h exp a=4 vec=%h", raddr_o, dvec, mvec());
      end
      tick();
      checks++;
      if (raddr_o !== 4'd5 || dvec !== mvec()) begin
         errors++; $display("FAIL run_begin2 got a=%0d exp a=5", raddr_o);
      end
      stop_run();
   endtask

   task automatic test_reset_midrun();
      sa_i = 4'd3; la_i = 4'd9; b_i = 1;
      tick(); b_i = 0;
      tick(); tick();
      checks++;
      if (raddr_o !== 4'd5 || cen_o !== 1'b1) begin errors++; $display("FAIL rst_pre got a=%0d c=%b exp a=5 c=1", raddr_o, cen_o); end
      rstn = 0;
      model_reset();
      #1;
      checks++;
      if (dvec !== '0) begin errors++; $display("FAIL rst_async got=%h exp=0", dvec); end
      tick();
      rstn = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (dvec !== '0 || dvec !== mvec()) begin errors++; $display("FAIL rst_idle[%0d] got=%h exp=0", i, dvec); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         sa_i  = AW'($urandom_range(0, MOD - 1));
         la_i  = AW'($urandom_range(0, MOD - 1));
         b_i   = ($urandom_range(0, 7) == 0);
         e_i   = ($urandom_range(0, 23) == 0);
         drc_i = ($urandom_range(0, 3) == 0);
         tick();
         checks++;
         if (dvec !== mvec()) begin errors++; $display("FAIL rand[%0d] got=%h exp=%h", i, dvec, mvec()); end
`ifdef MSGPASS_ADDRGEN_STALL_CNT_EN
         checks++;
         if (stall_cnt_o !== 16'(m_stall)) begin errors++; $display("FAIL rand_cnt[%0d] got=%0d exp=%0d", i, stall_cnt_o, m_stall); end
`endif
      end
      b_i = 0; e_i = 0; drc_i = 0;
   endtask

   initial begin
      test_reset();
      test_basic_walk();
      test_conflict_stall();
      test_rollover();
      test_stop_drain();
      test_pulses();
      test_reset_midrun();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
